// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: memory command encoding and FSM states.
package fetch_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDiscard
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO with flush; head entry and occupancy are registered.
module fetch_queue #(
  parameter int unsigned Width = 25,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       data_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       data_o,
  output logic                   valid_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] Full = (PtrW+1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok = push_i & ~flush_i & (count_q != Full);
    pop_ok  = pop_i & ~flush_i & (count_q != '0);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      // Pointers wrap naturally because Depth is a power of two.
      if (push_ok) wptr_d = wptr_q + PtrW'(1);
      if (pop_ok)  rptr_d = rptr_q + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (PtrW+1)'(1);
        2'b01:   count_d = count_q - (PtrW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction prefetch: one outstanding memory read feeding a small queue, with redirect flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 9,
  parameter int unsigned       INSTR_W  = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hold,
  output logic [1:0]         mem_cmd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_data,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW:0] DepthLim = (CntW+1)'(DEPTH);

  fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [CntW-1:0]   count;
  logic [CntW:0]     slots_used;
  logic [ADDR_W+INSTR_W-1:0] head;
  logic      resp, push, pop, pending_after, issue;
  mem_cmd_t  cmd;

  assign resp          = (state_q == StWait) & mem_ready;
  assign push          = resp & ~redirect;
  assign pop           = instr_valid & instr_ready & ~redirect;
  assign pending_after = (state_q == StWait) & ~mem_ready;

  // Occupancy after this cycle's push/pop; a same-cycle pop frees a slot for issue.
  assign slots_used = {1'b0, count} + (CntW+1)'(push) - (CntW+1)'(pop);

  assign issue = reset & ~hold & ~redirect & (state_q != StDiscard) & ~pending_after &
                 (slots_used < DepthLim);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    cmd        = MEM_NONE;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      // An in-flight read whose data has not arrived must be dropped later.
      if ((state_q != StIdle) && !mem_ready) state_d = StDiscard;
      else                                   state_d = StIdle;
    end else begin
      if ((state_q != StIdle) && mem_ready) state_d = StIdle;
      if (issue) begin
        cmd        = MEM_READ;
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        state_d    = StWait;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  assign mem_cmd  = cmd;
  assign mem_addr = fetch_pc_q;

  fetch_queue #(
    .Width(ADDR_W + INSTR_W),
    .Depth(DEPTH)
  ) u_queue (
    .clk_i  (clk),
    .rst_ni (reset),
    .flush_i(redirect),
    .push_i (push),
    .data_i ({req_pc_q, mem_data}),
    .pop_i  (pop),
    .data_o (head),
    .valid_o(instr_valid),
    .count_o(count)
  );

  assign instr    = head[INSTR_W-1:0];
  assign instr_pc = head[ADDR_W+INSTR_W-1:INSTR_W];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: bench-side memory model plus an expected-instruction scoreboard.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hold = 1'b0;
  logic        mem_ready = 1'b0;
  logic        redirect = 1'b0;
  logic        instr_ready = 1'b0;
  logic        instr_valid;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [8:0]  redirect_pc = 9'h000;
  logic [8:0]  instr_pc;
  logic [15:0] mem_data = 16'h0000;
  logic [15:0] instr;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  int reads = 0;
  int pops = 0;
  int r0, p0;

  logic       pend = 1'b0;
  logic       stall = 1'b0;
  logic       discard = 1'b0;
  logic       late = 1'b0;
  logic [8:0] pend_addr = 9'h000;
  logic [8:0] exp_pc = 9'h000;
  logic [24:0] sb[$];

  fetch_unit #(
    .ADDR_W(9),
    .INSTR_W(16),
    .DEPTH(4),
    .RESET_PC(9'h000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_data   (mem_data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_fn(input logic [8:0] a);
    return {a[3:0], 3'b101, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive memory response, sample just before the edge, update the model.
  task automatic cycle();
    logic resp;
    logic busy;
    logic [24:0] e;
    resp = pend & ~stall;
    busy = pend & ~resp;
    mem_ready = resp | late;
    mem_data = discard ? 16'hBEEF : (resp ? mem_fn(pend_addr) : 16'hDEAD);
    #3;
    if (hold) chk("hold_no_read", 32'(mem_cmd), 32'(MEM_NONE));
    if (redirect) chk("redirect_no_read", 32'(mem_cmd), 32'(MEM_NONE));
    if (instr_valid && instr_ready && !redirect) begin
      pops++;
      if (sb.size() == 0) chk("unexpected_instr", 32'(instr_valid), 32'd0);
      else begin
        e = sb.pop_front();
        chk("instr_pc", 32'(instr_pc), 32'(e[24:16]));
        chk("instr_data", 32'(instr), 32'(e[15:0]));
      end
    end
    if (resp) begin
      if (!redirect && !discard) sb.push_back({pend_addr, mem_data});
      pend = 1'b0;
      discard = 1'b0;
    end
    if (mem_cmd == MEM_READ) begin
      if (busy) chk("single_outstanding", 32'(mem_cmd), 32'(MEM_NONE));
      chk("mem_addr", 32'(mem_addr), 32'(exp_pc));
      reads++;
      pend = 1'b1;
      pend_addr = exp_pc;
      exp_pc = exp_pc + 9'd1;
    end
    if (redirect) begin
      if (pend && !resp) discard = 1'b1;
      sb.delete();
      exp_pc = redirect_pc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pend = 1'b0;
    discard = 1'b0;
    late = 1'b0;
    stall = 1'b0;
    mem_ready = 1'b0;
    sb.delete();
    exp_pc = 9'h000;
    #2;
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_mem_cmd", 32'(mem_cmd), 32'(MEM_NONE));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // Streaming with a 1-cycle memory and an always-ready consumer.
    instr_ready = 1'b1;
    do_reset();
    reads = 0;
    pops = 0;
    repeat (8) cycle();
    chk("stream_reads", 32'(reads), 32'd8);
    chk("stream_pops", 32'(pops), 32'd6);

    // Consumer stalled: exactly DEPTH requests, then a pop frees a slot the same cycle.
    do_reset();
    instr_ready = 1'b0;
    reads = 0;
    repeat (8) cycle();
    chk("fill_reads", 32'(reads), 32'd4);
    chk("fill_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    cycle();
    chk("pop_frees_slot", 32'(reads), 32'd5);

    // Redirect while a read is outstanding: its data must be dropped.
    instr_ready = 1'b0;
    cycle();
    instr_ready = 1'b1;
    cycle();
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 9'h040;
    cycle();
    redirect = 1'b0;
    stall = 1'b0;
    chk("flush_valid", 32'(instr_valid), 32'd0);
    r0 = reads;
    cycle();
    chk("discard_no_issue", 32'(reads), 32'(r0));
    chk("discard_dropped", 32'(instr_valid), 32'd0);
    p0 = pops;
    repeat (3) cycle();
    chk("redirect_first_pop", 32'(pops), 32'(p0 + 1));

    // Redirect coincident with the response.
    redirect = 1'b1;
    redirect_pc = 9'h100;
    cycle();
    redirect = 1'b0;
    r0 = reads;
    cycle();
    chk("redir_ready_issue", 32'(reads), 32'(r0 + 1));
    repeat (2) cycle();

    // Data-side hold: no fetches, queue still drains, then sequential resume.
    hold = 1'b1;
    r0 = reads;
    p0 = pops;
    repeat (3) cycle();
    chk("hold_reads", 32'(reads), 32'(r0));
    chk("hold_pops", 32'(pops), 32'(p0 + 2));
    hold = 1'b0;
    cycle();
    chk("hold_resume", 32'(reads), 32'(r0 + 1));

    // Reset while a read is outstanding; its late response must be ignored.
    stall = 1'b1;
    do_reset();
    late = 1'b1;
    chk("post_rst_valid", 32'(instr_valid), 32'd0);
    r0 = reads;
    cycle();
    late = 1'b0;
    chk("first_after_rst", 32'(reads), 32'(r0 + 1));
    chk("late_ignored", 32'(instr_valid), 32'd0);
    p0 = pops;
    repeat (4) cycle();
    chk("post_rst_pops", 32'(pops), 32'(p0 + 3));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
